ethernet_rx: RTL and testbench

ETHERNET_RX -- requirements
Module: ethernet_rx

---
 rtl/ethernet_rx.sv | 213 +++++++++++++++++++++
 tb/tb_ethernet_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_rx.sv
// RMII-style Ethernet receiver: nibble assembly, address filter, header capture,
// FCS-stripping payload stream and end-of-frame status with CRC-32 check.
module ethernet_rx #(
  parameter int          N      = 4,
  parameter logic [47:0] MY_MAC = 48'h37_38_38_38_38_38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] eth_rxd,
  input  logic         eth_crsdv,
  output logic         axiov,
  output logic [7:0]   axiod,
  output logic         hdr_valid,
  output logic [47:0]  src_mac,
  output logic [15:0]  etype,
  output logic         frame_done,
  output logic         frame_ok,
  output logic [3:0]   err,
  output logic [10:0]  byte_count
);
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MAX_BYTES   = 11'd1518;
  localparam logic [10:0] MIN_BYTES   = 11'd64;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DEST, SRC, ETYPE, PAYLOAD, DROP} state_e;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    pre_cnt_q, pre_cnt_d;
  logic          nib_hi_q, nib_hi_d;
  logic [N-1:0]  low_nib_q, low_nib_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [2:0]    field_cnt_q, field_cnt_d;
  logic [47:0]   dest_q, dest_d;
  logic [47:0]   src_sh_q, src_sh_d;
  logic [7:0]    etype_hi_q, etype_hi_d;
  logic [31:0]   crc_q, crc_d;
  logic [7:0]    dly_q [4];
  logic [7:0]    dly_d [4];
  logic [2:0]    fill_q, fill_d;
  logic          oversize_q, oversize_d;
  logic          armed_q, armed_d;
  logic          axiov_q, axiov_d;
  logic [7:0]    axiod_q, axiod_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic [47:0]   src_mac_q, src_mac_d;
  logic [15:0]   etype_q, etype_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_ok_q, frame_ok_d;
  logic [3:0]    err_q, err_d;
  logic [10:0]   byte_count_q, byte_count_d;

  logic [7:0]    rx_byte;
  logic [47:0]   dest_next;
  logic [3:0]    err_now;
  logic          reporting, tracking;

  assign rx_byte   = {eth_rxd, low_nib_q};
  assign dest_next = {dest_q[39:0], rx_byte};
  assign err_now   = {nib_hi_q, oversize_q, (cnt_q < MIN_BYTES), (crc_q != CRC_RESIDUE)};
  // An oversize frame keeps being tracked in DROP so it can still report status.
  assign reporting = (state_q inside {SRC, ETYPE, PAYLOAD}) || (state_q == DROP && oversize_q);
  assign tracking  = (state_q inside {DEST, SRC, ETYPE, PAYLOAD}) || (state_q == DROP && oversize_q);

  // NOTE: every _d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d      = state_q;      pre_cnt_d    = pre_cnt_q;   nib_hi_d   = nib_hi_q;
    low_nib_d    = low_nib_q;    cnt_d        = cnt_q;       field_cnt_d = field_cnt_q;
    dest_d       = dest_q;       src_sh_d     = src_sh_q;    etype_hi_d = etype_hi_q;
    crc_d        = crc_q;        dly_d        = dly_q;       fill_d     = fill_q;
    oversize_d   = oversize_q;   axiod_d      = axiod_q;     src_mac_d  = src_mac_q;
    etype_d      = etype_q;      frame_ok_d   = frame_ok_q;  err_d      = err_q;
    byte_count_d = byte_count_q;
    axiov_d      = 1'b0;
    hdr_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    armed_d      = armed_q | ~eth_crsdv;

    if (!eth_crsdv) begin
      state_d    = IDLE;
      oversize_d = 1'b0;
      if (reporting) begin
        frame_done_d = 1'b1;
        err_d        = err_now;
        frame_ok_d   = (err_now == 4'd0);
        byte_count_d = cnt_q;
      end
    end else begin
      if (tracking) begin
        crc_d    = crc_nib(crc_q, eth_rxd);
        nib_hi_d = ~nib_hi_q;
        if (!nib_hi_q) low_nib_d = eth_rxd;
      end
      case (state_q)
        IDLE: begin
          if (armed_q && eth_rxd == 4'h5) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 2'd1;
          end
        end
        PREAMBLE: begin
          if (eth_rxd == 4'h5) begin
            if (pre_cnt_q != 2'd3) pre_cnt_d = pre_cnt_q + 2'd1;
          end else if (eth_rxd == 4'hD && pre_cnt_q >= 2'd2) begin
            state_d     = DEST;
            crc_d       = 32'hFFFF_FFFF;
            nib_hi_d    = 1'b0;
            cnt_d       = 11'd0;
            field_cnt_d = 3'd0;
            oversize_d  = 1'b0;
          end else begin
            state_d = DROP;
          end
        end
        DEST, SRC, ETYPE, PAYLOAD: begin
          if (nib_hi_q) begin
            if (cnt_q == MAX_BYTES) begin
              oversize_d = 1'b1;
              state_d    = DROP;
            end else begin
              cnt_d = cnt_q + 11'd1;
              case (state_q)
                DEST: begin
                  dest_d      = dest_next;
                  field_cnt_d = field_cnt_q + 3'd1;
                  if (field_cnt_q == 3'd5) begin
                    field_cnt_d = 3'd0;
                    state_d = (dest_next == MY_MAC || dest_next == 48'hFFFF_FFFF_FFFF) ? SRC : DROP;
                  end
                end
                SRC: begin
                  src_sh_d    = {src_sh_q[39:0], rx_byte};
                  field_cnt_d = field_cnt_q + 3'd1;
                  if (field_cnt_q == 3'd5) begin
                    field_cnt_d = 3'd0;
                    state_d     = ETYPE;
                  end
                end
                ETYPE: begin
                  if (field_cnt_q == 3'd0) begin
                    etype_hi_d  = rx_byte;
                    field_cnt_d = 3'd1;
                  end else begin
                    src_mac_d   = src_sh_q;
                    etype_d     = {etype_hi_q, rx_byte};
                    hdr_valid_d = 1'b1;
                    fill_d      = 3'd0;
                    state_d     = PAYLOAD;
                  end
                end
                default: begin
                  // A byte leaves only once four newer ones are queued, so the FCS stays behind.
                  if (fill_q == 3'd4) begin
                    axiov_d = 1'b1;
                    axiod_d = dly_q[3];
                  end else begin
                    fill_d = fill_q + 3'd1;
                  end
                  dly_d[3] = dly_q[2];
                  dly_d[2] = dly_q[1];
                  dly_d[1] = dly_q[0];
                  dly_d[0] = rx_byte;
                end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;       pre_cnt_q <= '0;    nib_hi_q <= 1'b0;   low_nib_q <= '0;
      cnt_q <= '0;           field_cnt_q <= '0;  dest_q <= '0;       src_sh_q <= '0;
      etype_hi_q <= '0;      crc_q <= '0;        fill_q <= '0;       oversize_q <= 1'b0;
      armed_q <= 1'b0;       axiov_q <= 1'b0;    axiod_q <= '0;      hdr_valid_q <= 1'b0;
      src_mac_q <= '0;       etype_q <= '0;      frame_done_q <= 1'b0;
      frame_ok_q <= 1'b0;    err_q <= '0;        byte_count_q <= '0;
      // NOTE: the delay line is a tiny register array, so it is cleared with everything else.
      dly_q <= '{default: '0};
    end else begin
      state_q <= state_d;       pre_cnt_q <= pre_cnt_d;     nib_hi_q <= nib_hi_d;
      low_nib_q <= low_nib_d;   cnt_q <= cnt_d;             field_cnt_q <= field_cnt_d;
      dest_q <= dest_d;         src_sh_q <= src_sh_d;       etype_hi_q <= etype_hi_d;
      crc_q <= crc_d;           fill_q <= fill_d;           oversize_q <= oversize_d;
      armed_q <= armed_d;       axiov_q <= axiov_d;         axiod_q <= axiod_d;
      hdr_valid_q <= hdr_valid_d; src_mac_q <= src_mac_d;   etype_q <= etype_d;
      frame_done_q <= frame_done_d; frame_ok_q <= frame_ok_d; err_q <= err_d;
      byte_count_q <= byte_count_d;
      dly_q <= dly_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign hdr_valid  = hdr_valid_q;
  assign src_mac    = src_mac_q;
  assign etype      = etype_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;
endmodule

// File: tb/tb_ethernet_rx.sv
// Scoreboard bench for ethernet_rx: frames are built with a byte-wise CRC model,
// expected header/payload/status are queued at send time and popped by a monitor.
module tb_ethernet_rx;
  localparam logic [47:0] MY  = 48'h37_38_38_38_38_38;
  localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct packed {
    logic        full;
    logic [3:0]  err;
    logic [3:0]  mask;
    logic [10:0] cnt;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  eth_rxd;
  logic        eth_crsdv;
  logic        axiov, hdr_valid, frame_done, frame_ok;
  logic [7:0]  axiod;
  logic [47:0] src_mac;
  logic [15:0] etype;
  logic [3:0]  err;
  logic [10:0] byte_count;

  logic [7:0]  frame_q[$];
  logic [7:0]  exp_bytes[$];
  logic [63:0] exp_hdr[$];
  done_t       exp_done[$];
  int          n_checks = 0;
  int          n_pass = 0;

  ethernet_rx dut (
    .clk(clk), .rst(rst), .eth_rxd(eth_rxd), .eth_crsdv(eth_crsdv),
    .axiov(axiov), .axiod(axiod), .hdr_valid(hdr_valid), .src_mac(src_mac),
    .etype(etype), .frame_done(frame_done), .frame_ok(frame_ok), .err(err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_outputs_zero();
    check("rst_axiov", axiov, 0);          check("rst_axiod", axiod, 0);
    check("rst_hdr_valid", hdr_valid, 0);  check("rst_src_mac", src_mac, 0);
    check("rst_etype", etype, 0);          check("rst_frame_done", frame_done, 0);
    check("rst_frame_ok", frame_ok, 0);    check("rst_err", err, 0);
    check("rst_byte_count", byte_count, 0);
  endtask

  task automatic make_frame(input logic [47:0] dest, input int plen);
    logic [47:0] s;
    logic [31:0] crc;
    logic [7:0]  b;
    s = SRC;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(dest[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(s[47-8*i -: 8]);
    frame_q.push_back(8'h08);
    frame_q.push_back(8'h00);
    for (int i = 0; i < plen; i++) frame_q.push_back(8'(i));
    crc = 32'hFFFF_FFFF;
    foreach (frame_q[i]) begin
      b = frame_q[i];
      crc = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) frame_q.push_back(crc[8*i +: 8]);
  endtask

  task automatic expect_frame(input logic full, input logic [3:0] e, input logic [3:0] m,
                              input logic [10:0] cnt);
    int lim;
    done_t d;
    lim = (frame_q.size() > 1518) ? 1518 : frame_q.size();
    exp_hdr.push_back({SRC, 16'h0800});
    for (int k = 14; k <= lim - 5; k++) exp_bytes.push_back(frame_q[k]);
    d.full = full; d.err = e; d.mask = m; d.cnt = cnt;
    exp_done.push_back(d);
  endtask

  task automatic send_frame(input int n_pre, input logic [3:0] sfd, input bit odd_nib,
                            input int rst_byte);
    @(negedge clk);
    eth_crsdv = 1'b1;
    for (int i = 0; i < n_pre; i++) begin
      eth_rxd = 4'h5;
      @(negedge clk);
    end
    eth_rxd = sfd;
    @(negedge clk);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == rst_byte) begin
        rst = 1'b0;
        #1;
        check_outputs_zero();
        exp_bytes.delete(); exp_hdr.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
      eth_rxd = frame_q[i][3:0];
      @(negedge clk);
      eth_rxd = frame_q[i][7:4];
      @(negedge clk);
    end
    if (odd_nib) begin
      eth_rxd = 4'h3;
      @(negedge clk);
    end
    eth_crsdv = 1'b0;
    eth_rxd = 4'h0;
    repeat (12) @(negedge clk);
    check("bytes_left", exp_bytes.size(), 0);
    check("hdr_left", exp_hdr.size(), 0);
    check("done_left", exp_done.size(), 0);
  endtask

  logic [7:0]  mon_b;
  logic [63:0] mon_h;
  done_t       mon_d;

  always @(negedge clk) begin
    if (rst) begin
      if (axiov) begin
        if (exp_bytes.size() == 0) check("axiov_unexpected", 1, 0);
        else begin
          mon_b = exp_bytes.pop_front();
          check("axiod", axiod, mon_b);
        end
      end
      if (hdr_valid) begin
        if (exp_hdr.size() == 0) check("hdr_unexpected", 1, 0);
        else begin
          mon_h = exp_hdr.pop_front();
          check("src_mac", src_mac, mon_h[63:16]);
          check("etype", etype, mon_h[15:0]);
        end
      end
      if (frame_done) begin
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_d = exp_done.pop_front();
          if (mon_d.full) begin
            check("err", err, mon_d.err);
            check("frame_ok", frame_ok, mon_d.err == 4'd0);
            check("byte_count", byte_count, mon_d.cnt);
          end else begin
            check("err_flag", err & mon_d.mask, mon_d.err & mon_d.mask);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    eth_crsdv = 1'b0;
    eth_rxd = 4'h0;
    repeat (2) @(negedge clk);
    check_outputs_zero();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    make_frame(MY, 46);                       // good 64-byte frame
    expect_frame(1'b1, 4'b0000, 4'hF, 11'd64);
    send_frame(7, 4'hD, 1'b0, -1);

    make_frame(BC, 46);                       // broadcast
    expect_frame(1'b1, 4'b0000, 4'hF, 11'd64);
    send_frame(7, 4'hD, 1'b0, -1);

    make_frame(48'h11_22_33_44_55_66, 46);    // foreign address: silent
    send_frame(7, 4'hD, 1'b0, -1);

    make_frame(MY, 46);                       // payload bit flip
    frame_q[20] = frame_q[20] ^ 8'h01;
    expect_frame(1'b1, 4'b0001, 4'hF, 11'd64);
    send_frame(7, 4'hD, 1'b0, -1);

    make_frame(MY, 22);                       // runt, valid FCS
    expect_frame(1'b1, 4'b0010, 4'hF, 11'd40);
    send_frame(7, 4'hD, 1'b0, -1);

    make_frame(MY, 1501);                     // 1519 bytes: oversize
    expect_frame(1'b0, 4'b0100, 4'b0100, 11'd0);
    send_frame(7, 4'hD, 1'b0, -1);

    make_frame(MY, 46);                       // trailing odd nibble
    expect_frame(1'b0, 4'b1000, 4'b1000, 11'd0);
    send_frame(7, 4'hD, 1'b1, -1);

    make_frame(MY, 46);                       // bad preamble 5,5,A
    send_frame(2, 4'hA, 1'b0, -1);

    make_frame(MY, 46);                       // shortest accepted preamble 5,5,D
    expect_frame(1'b1, 4'b0000, 4'hF, 11'd64);
    send_frame(2, 4'hD, 1'b0, -1);

    make_frame(MY, 46);                       // reset at payload byte 10
    expect_frame(1'b1, 4'b0000, 4'hF, 11'd64);
    send_frame(7, 4'hD, 1'b0, 24);

    make_frame(MY, 46);                       // recovery after reset
    expect_frame(1'b1, 4'b0000, 4'hF, 11'd64);
    send_frame(7, 4'hD, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
